ntt_addr_gen: RTL
=================

# ntt_addr_gen

Sequencing controller for the in-place radix-2 NTT/INTT datapath. Sits directly upstream of the butterfly: it walks all LOGN layers of an N-point transform and issues per-cycle coefficient-RAM read addresses, the twiddle-ROM address and the butterfly mode. It emits matching write-back addresses delayed by the pipeline latency, and stalls between layers so that no read-after-write hazard reaches the coefficient RAM.

## Interface
- LOGN, 8: log2 of transform size; N = 2^LOGN, N/2 butterflies per layer.
- PIPE_LAT, 4: cycles from rd_en to the corresponding write (RAM read + butterfly latency); must be at least 1.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- start  in  1  one-cycle request; sampled only in IDLE.
- inv  in  1  0 = forward NTT, 1 = INTT; latched when start is accepted.
- busy  out  1  high from the first issue cycle through the last drain cycle.
- done  out  1  one-cycle pulse after the final layer has drained.
- rd_en  out  1  butterfly input pair valid this cycle.
- rd_addr_a, rd_addr_b  out  LOGN each  coefficient-RAM read addresses (a, b ports).
- tw_addr  out  LOGN  twiddle-ROM address.
- bf_mode  out  2  butterfly mode: 00 NTT, 01 INTT while rd_en=1; 11 (idle) otherwise.
- wr_en  out  1  write-back valid.
- wr_addr_a, wr_addr_b  out  LOGN each  write-back addresses for outputs c, d.

## Operation
- States:
  - IDLE: start=1 goes to ISSUE, latches inv, clears counters.
  - ISSUE: one butterfly per cycle for N/2 cycles, then goes to DRAIN.
  - DRAIN: runs exactly PIPE_LAT cycles. Goes to ISSUE if more layers remain, otherwise to DONE.
  - DONE: one cycle, then IDLE.
- Layer len (distance between a and b):
  - NTT: starts at N/2 and halves after each layer.
  - INTT: starts at 1 and doubles after each layer.
- Inside a layer:
  - Groups start at base = 0, 2·len, 4·len, …
  - For each group, j runs 0..len-1, with rd_addr_a = base+j and rd_addr_b = base+j+len.
  - Group-major order; j is the innermost loop.
- Twiddle index k, held constant for a whole group:
  - NTT: k=1 for the first group, incremented per group over the whole transform, ending at N-1.
  - INTT: k=N-1 for the first group, decremented per group, ending at 1.
  - tw_addr=k.
- Write-back: wr_en, wr_addr_a and wr_addr_b are rd_en, rd_addr_a and rd_addr_b delayed by exactly PIPE_LAT cycles through a shift register.
- start while not IDLE is ignored. inv changes after acceptance have no effect.
- All address arithmetic is modulo 2^LOGN, but legal sequences never wrap.

## Timing
- Reset values: all outputs 0 except bf_mode=11. The write-back shift register is cleared.
- Reset mid-operation asynchronously forces IDLE, kills all pending writes, and suppresses done.
- Start accepted at edge T0:
  - Layer L (0-based) issues in cycles T0+1+L·(N/2+PIPE_LAT) through T0+L·(N/2+PIPE_LAT)+N/2.
  - DRAIN follows each layer.
- done is high in cycle T0+1+LOGN·(N/2+PIPE_LAT), with busy=0 in that cycle. busy is high in every cycle before it, back to T0+1.
- The last write of each layer lands in the final DRAIN cycle, so the next layer's first read sees updated data.
- A start arriving in the DONE cycle is ignored. It is accepted from the following IDLE cycle onward.

## Test plan
- NTT, LOGN=3, PIPE_LAT=4, start at T0 -> issue sequence:
  - layer 0 (cycles 1-4): (0,4),(1,5),(2,6),(3,7), tw 1.
  - layer 1 (9-12): (0,2),(1,3) tw 2; (4,6),(5,7) tw 3.
  - layer 2 (17-20): (0,1) tw 4, (2,3) tw 5, (4,5) tw 6, (6,7) tw 7.
  - done at cycle 25.
- INTT, same parameters -> layer 0: (0,1) tw 7, (2,3) tw 6, (4,5) tw 5, (6,7) tw 4. Layer 1: (0,2),(1,3) tw 3; (4,6),(5,7) tw 2. Layer 2: (0,4)…(3,7) tw 1. bf_mode=01 on every issue cycle.
- Write-back alignment -> wr_en first high at cycle 5 with (0,4), last high at cycle 24 with (6,7). wr_en is never high in a cycle where rd_en reads the same layer's addresses after DRAIN.
- start pulsed at cycles 3 and 25 during a run -> both ignored. A start at cycle 26 begins a new run with first issue at cycle 27.
- rst low at cycle 10 -> same cycle: rd_en=wr_en=0, bf_mode=11, busy=0, and no done afterwards. Release rst plus start -> a full correct sequence runs.
- LOGN=8, PIPE_LAT=4, NTT -> done at cycle 8·(128+4)+1=1057. tw_addr reaches 255 exactly once. Exactly 1024 wr_en cycles.

Source files
------------

// File: rtl/ntt_addr_gen.sv
// Address/sequencing controller for an in-place radix-2 NTT/INTT butterfly datapath.
// Walks LOGN layers, issues read/twiddle addresses and replays them as write-backs PIPE_LAT cycles later.
module ntt_addr_gen #(
  parameter int unsigned LOGN     = 8,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            inv,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic [1:0]      bf_mode,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int unsigned N    = 1 << LOGN;
  localparam int unsigned LW   = $clog2(LOGN + 1);
  localparam int unsigned DW   = $clog2(PIPE_LAT + 1);
  localparam logic [LOGN-1:0] HALF = LOGN'(N / 2);
  localparam logic [LOGN-1:0] KMAX = LOGN'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nx;
  logic            inv_q;
  logic [LOGN-1:0] len, base, j, k, cnt;
  logic [LW-1:0]   layer;
  logic [DW-1:0]   dcnt;
  logic            group_end, issue_end, drain_end, last_layer;

  logic            wv [PIPE_LAT];
  logic [LOGN-1:0] wa [PIPE_LAT];
  logic [LOGN-1:0] wb [PIPE_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    group_end  = (j == len - LOGN'(1));
    issue_end  = (cnt == HALF - LOGN'(1));
    drain_end  = (dcnt == DW'(PIPE_LAT - 1));
    last_layer = (layer == LW'(LOGN - 1));
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    bf_mode    = 2'b11;
    rd_addr_a  = '0;
    rd_addr_b  = '0;
    tw_addr    = '0;
    case (state)
      S_IDLE: if (start) state_nx = S_ISSUE;
      S_ISSUE: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        bf_mode   = {1'b0, inv_q};
        rd_addr_a = base + j;
        rd_addr_b = base + j + len;
        tw_addr   = k;
        if (issue_end) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_end) state_nx = last_layer ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // k runs continuously across layer boundaries, so only base/len restart per layer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inv_q <= 1'b0;
      len   <= '0;
      base  <= '0;
      j     <= '0;
      k     <= '0;
      cnt   <= '0;
      layer <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          inv_q <= inv;
          len   <= inv ? LOGN'(1) : HALF;
          k     <= inv ? KMAX : LOGN'(1);
          base  <= '0;
          j     <= '0;
          cnt   <= '0;
          layer <= '0;
          dcnt  <= '0;
        end
        S_ISSUE: begin
          cnt <= cnt + LOGN'(1);
          if (group_end) begin
            j    <= '0;
            base <= base + (len << 1);
            k    <= inv_q ? k - LOGN'(1) : k + LOGN'(1);
          end else begin
            j <= j + LOGN'(1);
          end
          if (issue_end) begin
            cnt  <= '0;
            base <= '0;
            len  <= inv_q ? (len << 1) : (len >> 1);
            dcnt <= '0;
          end
        end
        S_DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (drain_end) layer <= layer + LW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        wv[i] <= 1'b0;
        wa[i] <= '0;
        wb[i] <= '0;
      end
    end else begin
      wv[0] <= rd_en;
      wa[0] <= rd_addr_a;
      wb[0] <= rd_addr_b;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        wv[i] <= wv[i-1];
        wa[i] <= wa[i-1];
        wb[i] <= wb[i-1];
      end
    end
  end

  assign wr_en     = wv[PIPE_LAT-1];
  assign wr_addr_a = wa[PIPE_LAT-1];
  assign wr_addr_b = wb[PIPE_LAT-1];

endmodule
